// File: rtl/loopback_pu_sequencer.sv
// Counted, flow-controlled PU loopback: one start moves num_words stream words
// through a small skid FIFO to the stream write port and drains num_buf_words buffer reads.
module loopback_pu_sequencer #(
  parameter int AXI_DATA_W = 64,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_words,
  input  logic [CNT_W-1:0]      num_buf_words,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      words_written,
  input  logic                  stream_read_ready,
  output logic                  stream_read_req,
  input  logic [AXI_DATA_W-1:0] stream_read_data,
  input  logic                  buffer_read_ready,
  output logic                  buffer_read_req,
  input  logic [AXI_DATA_W-1:0] buffer_read_data,
  input  logic                  stream_write_ready,
  output logic                  stream_write_req,
  output logic [AXI_DATA_W-1:0] stream_write_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      len_words, len_buf;
  logic [CNT_W-1:0]      rd_cnt, wr_cnt, buf_cnt;
  logic [AXI_DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        occ;
  logic [PTR_W+1:0]      credit_used;
  logic                  vld_p1;
  logic                  start_acc, run, push, pop, fifo_empty;
  logic                  unused_buf_data;

  assign unused_buf_data = ^buffer_read_data;

  assign start_acc   = (state == IDLE) && start;
  assign run         = (state == RUN);
  assign fifo_empty  = (occ == '0);
  assign push        = vld_p1;
  assign pop         = stream_write_req;
  // Entries already stored plus the word still in flight must leave room for one more.
  assign credit_used = {1'b0, occ} + {{(PTR_W+1){1'b0}}, vld_p1};

  assign stream_read_req   = run && stream_read_ready && (rd_cnt < len_words) &&
                             (credit_used < (PTR_W+2)'(FIFO_DEPTH));
  assign buffer_read_req   = run && buffer_read_ready && (buf_cnt < len_buf);
  assign stream_write_req  = !fifo_empty && stream_write_ready;
  assign stream_write_data = fifo_empty ? '0 : mem[rd_ptr];

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign words_written = wr_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if ((wr_cnt == len_words) && (buf_cnt == len_buf)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      len_words <= '0;
      len_buf   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      buf_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        len_words <= num_words;
        len_buf   <= num_buf_words;
        rd_cnt    <= '0;
        wr_cnt    <= '0;
        buf_cnt   <= '0;
      end else begin
        if (stream_read_req) rd_cnt <= rd_cnt + CNT_W'(1);
        if (buffer_read_req) buf_cnt <= buf_cnt + CNT_W'(1);
        if (pop && (wr_cnt < len_words)) wr_cnt <= wr_cnt + CNT_W'(1);
      end
    end
  end

  // Stage p1: read request issued last cycle, data arrives on stream_read_data now.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      vld_p1 <= stream_read_req;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stream_read_data;
  end

endmodule

// File: tb/tb_loopback_pu_sequencer.sv
// Randomized scoreboard bench: every word handed out on the stream read port must
// reappear once, in order, on the stream write port; command bookkeeping checked per run.
module tb_loopback_pu_sequencer;
  localparam int DW    = 64;
  localparam int CW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic [CW-1:0] num_buf_words = '0;
  logic          busy, done;
  logic [CW-1:0] words_written;
  logic          stream_read_ready = 1'b1;
  logic          stream_read_req;
  logic [DW-1:0] stream_read_data = '0;
  logic          buffer_read_ready = 1'b1;
  logic          buffer_read_req;
  logic [DW-1:0] buffer_read_data = 64'hdead_beef_0bad_f00d;
  logic          stream_write_ready = 1'b1;
  logic          stream_write_req;
  logic [DW-1:0] stream_write_data;

  loopback_pu_sequencer #(.AXI_DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .num_words(num_words), .num_buf_words(num_buf_words),
    .busy(busy), .done(done), .words_written(words_written),
    .stream_read_ready(stream_read_ready), .stream_read_req(stream_read_req),
    .stream_read_data(stream_read_data),
    .buffer_read_ready(buffer_read_ready), .buffer_read_req(buffer_read_req),
    .buffer_read_data(buffer_read_data),
    .stream_write_ready(stream_write_ready), .stream_write_req(stream_write_req),
    .stream_write_data(stream_write_data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [DW-1:0] exp_q[$];
  int rd_issued = 0, wr_done = 0, buf_reqs = 0, done_cnt = 0, busy_cyc = 0;
  int cyc = 0, last_buf_cyc = 0, done_cyc = 0;
  int wmode = 0, bmode = 0, dmode = 0;
  logic [DW-1:0] seq_val = '0;
  logic rd_pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Ready patterns: 0 = always ready, 1 = write ready 1 cycle in 4 / buffer held off 4 cycles, 2 = random.
  always @(posedge clk) begin
    #1;
    cyc++;
    stream_read_ready  = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    stream_write_ready = (wmode == 0) ? 1'b1 :
                         (wmode == 1) ? ((cyc % 4) == 3) : 1'($urandom_range(0, 1));
    buffer_read_ready  = (bmode == 1 && cyc <= 4) ? 1'b0 :
                         (bmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Stream read memory: answers each request one cycle later and records the word it gave.
  always @(negedge clk) begin
    logic [DW-1:0] d;
    if (!resetn) begin
      rd_pend = 1'b0;
    end else begin
      if (rd_pend) begin
        d = (dmode == 0) ? seq_val : {$urandom, $urandom};
        seq_val = seq_val + 1;
        stream_read_data = d;
        exp_q.push_back(d);
      end else begin
        stream_read_data = {$urandom, $urandom};
      end
      rd_pend = stream_read_req;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (buffer_read_req) begin buf_reqs++; last_buf_cyc = cyc; end
      if (stream_read_req) begin
        check("read_credit", 64'((rd_issued - wr_done) < DEPTH), 64'd1);
        rd_issued++;
      end
      if (stream_write_req) begin
        if (exp_q.size() == 0) check("write_unexpected", 64'd1, 64'd0);
        else check("write_data", stream_write_data, exp_q.pop_front());
        wr_done++;
      end
    end
  end

  task automatic clear_counts();
    rd_issued = 0; wr_done = 0; buf_reqs = 0; done_cnt = 0; busy_cyc = 0;
  endtask

  task automatic issue(input int nw, input int nb);
    @(posedge clk); #2;
    clear_counts();
    cyc = 0;
    start = 1'b1;
    num_words = CW'(nw);
    num_buf_words = CW'(nb);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout", 64'(done_cnt > 0), 64'd1);
  endtask

  task automatic end_checks(input int nw, input int nb);
    @(negedge clk); #1;
    check("busy_after_done", 64'(busy), 64'd0);
    check("stream_reads", 64'(rd_issued), 64'(nw));
    check("stream_writes", 64'(wr_done), 64'(nw));
    check("buffer_reads", 64'(buf_reqs), 64'(nb));
    check("words_written", 64'(words_written), 64'(nw));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("words_written_hold", 64'(words_written), 64'(nw));
  endtask

  task automatic run_cmd(input int nw, input int nb);
    issue(nw, nb);
    wait_done();
    end_checks(nw, nb);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_srd_req"}, 64'(stream_read_req), 64'd0);
    check({tag, "_brd_req"}, 64'(buffer_read_req), 64'd0);
    check({tag, "_wr_req"}, 64'(stream_write_req), 64'd0);
    check({tag, "_words_written"}, 64'(words_written), 64'd0);
    check({tag, "_wr_data"}, stream_write_data, 64'd0);
  endtask

  initial begin
    int nw, nb, n;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    resetn = 1'b1;

    // In-order loopback of 0..7, everything ready
    wmode = 0; bmode = 0; dmode = 0; seq_val = '0;
    run_cmd(8, 0);

    // Write back-pressure: 3 cycles low, 1 high
    wmode = 1; dmode = 1;
    run_cmd(16, 0);

    // Buffer-only command with buffer port held off at first
    wmode = 0; bmode = 1;
    run_cmd(0, 5);
    check("done_after_last_buf", 64'(done_cyc - last_buf_cyc), 64'd2);
    bmode = 0;

    // Zero-length command
    issue(0, 0);
    wait_done();
    check("zero_len_busy_cycles", 64'(busy_cyc), 64'd2);
    end_checks(0, 0);

    // Start re-pulsed during RUN must be ignored
    wmode = 1;
    issue(10, 0);
    repeat (3) @(posedge clk);
    #2;
    start = 1'b1; num_words = CW'(3);
    @(posedge clk); #2;
    start = 1'b0;
    wait_done();
    end_checks(10, 0);

    // Asynchronous reset mid-command, then a clean command
    wmode = 0;
    issue(10, 0);
    n = 0;
    while (wr_done < 4 && n < 500) begin @(posedge clk); n++; end
    check("reset_point_reached", 64'(wr_done >= 4), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); @(posedge clk); #2;
    exp_q.delete();
    resetn = 1'b1;
    run_cmd(2, 0);

    // Randomized commands with random readies and data
    wmode = 2; bmode = 2; dmode = 1;
    for (int i = 0; i < 8; i++) begin
      nw = int'($urandom_range(0, 24));
      nb = int'($urandom_range(0, 10));
      run_cmd(nw, nb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
